// File: rtl/fpu_pkg.sv
// Shared FP constants and the multiplier scheduler's state type.
package fpu_pkg;

    localparam int unsigned EXP      = 8;
    localparam int unsigned MANTISSA = 23;
    localparam int unsigned FLEN     = 1 + EXP + MANTISSA;
    localparam int unsigned EXP_BIAS = 127;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        RESP   = 2'b10
    } sched_state_t;

endpackage

// File: rtl/fpu_mul_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request searching upward from ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_mul_sched.sv
// Shares one FP multiplier among NUM_REQ requesters: round-robin grant, operand
// launch with a programmable settle wait, and a single registered response port.
module fpu_mul_sched
    import fpu_pkg::*;
#(
    parameter int unsigned FLEN    = fpu_pkg::FLEN,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*FLEN-1:0]  req_rs1,
    input  logic [NUM_REQ*FLEN-1:0]  req_rs2,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     mul_en,
    output logic [FLEN-1:0]          mul_rs1,
    output logic [FLEN-1:0]          mul_rs2,
    input  logic [FLEN-1:0]          mul_result,
    input  logic                     mul_overflow,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [TAG_W-1:0]         resp_tag,
    output logic [FLEN-1:0]          resp_data,
    output logic                     resp_overflow
);

    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [3:0]      CNT_INIT = 4'(MUL_LAT - 1);

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  next_ptr;
    logic [3:0]       cnt;
    logic             arb_en;
    logic             grant_any;
    logic [FLEN-1:0]  sel_rs1;
    logic [FLEN-1:0]  sel_rs2;
    logic [TAG_W-1:0] sel_tag;

    // Grants only in IDLE, never during flush or while reset is held.
    assign arb_en = rst_n && !flush && (state == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (arb_en),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    assign grant_any = |req_ready;
    assign next_ptr  = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    assign sel_rs1   = req_rs1[grant_idx*FLEN +: FLEN];
    assign sel_rs2   = req_rs2[grant_idx*FLEN +: FLEN];
    assign sel_tag   = req_tag[grant_idx*TAG_W +: TAG_W];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            mul_en        <= 1'b0;
            mul_rs1       <= '0;
            mul_rs2       <= '0;
            resp_valid    <= 1'b0;
            resp_id       <= '0;
            resp_tag      <= '0;
            resp_data     <= '0;
            resp_overflow <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            mul_en     <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mul_rs1  <= sel_rs1;
                        mul_rs2  <= sel_rs2;
                        resp_id  <= grant_idx;
                        resp_tag <= sel_tag;
                        cnt      <= CNT_INIT;
                        rr_ptr   <= next_ptr;
                        mul_en   <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (cnt == '0) begin
                        resp_data     <= mul_result;
                        resp_overflow <= mul_overflow;
                        mul_en        <= 1'b0;
                        resp_valid    <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    mul_en     <= 1'b0;
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_sched.sv
// Drives two schedulers (MUL_LAT 1 and 3) with shared stimulus and checks them
// against a cycle-stamped transaction model plus directed constant checks.
module tb_fpu_mul_sched;
    import fpu_pkg::*;

    localparam int N = 2;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_rs1 = '0;
    logic [63:0] req_rs2 = '0;
    logic [9:0]  req_tag = '0;
    logic        resp_ready = 1'b0;

    always #5 CLK = ~CLK;

    logic [1:0]  rdy_a, rdy_b;
    logic        en_a, en_b, movf_a, movf_b, rv_a, rv_b, id_a, id_b, ovf_a, ovf_b;
    logic [31:0] rs1_a, rs1_b, rs2_a, rs2_b, mres_a, mres_b, data_a, data_b;
    logic [4:0]  tag_a, tag_b;

    // Reference FP multiply for normal operands; exact for the operand sets used here.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] f;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'h0 || b[30:0] == 31'h0) return {1'b0, s, 31'h0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - int'(EXP_BIAS);
        if (p[47]) begin
            f = p[46:24];
            e++;
        end else begin
            f = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, s, 31'h0};
        return {1'b0, s, e[7:0], f};
    endfunction

    // Multiplier stand-ins: garbage whenever not enabled.
    assign {movf_a, mres_a} = en_a ? fmul(rs1_a, rs2_a) : {1'b1, 32'hDEAD_BEEF};
    assign {movf_b, mres_b} = en_b ? fmul(rs1_b, rs2_b) : {1'b1, 32'hDEAD_BEEF};

    fpu_mul_sched #(.FLEN(32), .NUM_REQ(2), .ID_W(1), .TAG_W(5), .MUL_LAT(1)) dut_a (
        .CLK(CLK), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy_a),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .mul_en(en_a), .mul_rs1(rs1_a), .mul_rs2(rs2_a),
        .mul_result(mres_a), .mul_overflow(movf_a),
        .resp_valid(rv_a), .resp_ready(resp_ready), .resp_id(id_a),
        .resp_tag(tag_a), .resp_data(data_a), .resp_overflow(ovf_a)
    );

    fpu_mul_sched #(.FLEN(32), .NUM_REQ(2), .ID_W(1), .TAG_W(5), .MUL_LAT(3)) dut_b (
        .CLK(CLK), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy_b),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .mul_en(en_b), .mul_rs1(rs1_b), .mul_rs2(rs2_b),
        .mul_result(mres_b), .mul_overflow(movf_b),
        .resp_valid(rv_b), .resp_ready(resp_ready), .resp_id(id_b),
        .resp_tag(tag_b), .resp_data(data_b), .resp_overflow(ovf_b)
    );

    logic [1:0]  o_rdy[2];
    logic        o_en[2], o_rv[2], o_id[2], o_ovf[2];
    logic [31:0] o_rs1[2], o_rs2[2], o_data[2];
    logic [4:0]  o_tag[2];
    assign o_rdy[0] = rdy_a;  assign o_rdy[1] = rdy_b;
    assign o_en[0]  = en_a;   assign o_en[1]  = en_b;
    assign o_rv[0]  = rv_a;   assign o_rv[1]  = rv_b;
    assign o_id[0]  = id_a;   assign o_id[1]  = id_b;
    assign o_ovf[0] = ovf_a;  assign o_ovf[1] = ovf_b;
    assign o_rs1[0] = rs1_a;  assign o_rs1[1] = rs1_b;
    assign o_rs2[0] = rs2_a;  assign o_rs2[1] = rs2_b;
    assign o_data[0] = data_a; assign o_data[1] = data_b;
    assign o_tag[0] = tag_a;  assign o_tag[1] = tag_b;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction model: each accepted request is stamped with the cycle its response appears.
    int          cyc = 0;
    bit          busy[2];
    int          rcyc[2];
    int          ptr[2];
    logic [31:0] e_rs1[2], e_rs2[2];
    int          e_id[2];
    logic [4:0]  e_tag[2];
    logic [1:0]  grant_log[$];
    logic [31:0] data_log[$];
    int          id_log[$];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            busy[k] = 1'b0;
            ptr[k]  = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_req_ready[%0d]", tag, k), 64'(o_rdy[k]), 64'(0));
            chk($sformatf("%s_mul_en[%0d]", tag, k), 64'(o_en[k]), 64'(0));
            chk($sformatf("%s_mul_rs[%0d]", tag, k), {o_rs1[k], o_rs2[k]}, 64'(0));
            chk($sformatf("%s_resp_valid[%0d]", tag, k), 64'(o_rv[k]), 64'(0));
            chk($sformatf("%s_resp_fields[%0d]", tag, k),
                {25'h0, o_id[k], o_tag[k], o_ovf[k], o_data[k]}, 64'(0));
        end
    endtask

    task automatic step();
        int         win, idx;
        logic [1:0] exp_rdy;
        bit         launching, responding;
        logic [32:0] prod;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            win = -1;
            if (!busy[k] && !flush) begin
                for (int j = 0; j < N; j++) begin
                    idx = (ptr[k] + j) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            exp_rdy = (win >= 0) ? 2'(1 << win) : 2'b00;
            chk($sformatf("req_ready[%0d]", k), 64'(o_rdy[k]), 64'(exp_rdy));
            launching  = busy[k] && (cyc < rcyc[k]);
            responding = busy[k] && (cyc >= rcyc[k]);
            chk($sformatf("mul_en[%0d]", k), 64'(o_en[k]), 64'(launching));
            if (launching)
                chk($sformatf("mul_rs[%0d]", k), {o_rs1[k], o_rs2[k]}, {e_rs1[k], e_rs2[k]});
            chk($sformatf("resp_valid[%0d]", k), 64'(o_rv[k]), 64'(responding));
            if (responding) begin
                prod = fmul(e_rs1[k], e_rs2[k]);
                chk($sformatf("resp_id_tag[%0d]", k), {58'h0, o_id[k], o_tag[k]},
                    {58'h0, e_id[k] != 0, e_tag[k]});
                chk($sformatf("resp_data[%0d]", k), {31'h0, o_ovf[k], o_data[k]}, 64'(prod));
            end
            if (flush) begin
                busy[k] = 1'b0;
            end else if (win >= 0) begin
                busy[k]  = 1'b1;
                rcyc[k]  = cyc + lat(k) + 1;
                e_rs1[k] = req_rs1[win*32 +: 32];
                e_rs2[k] = req_rs2[win*32 +: 32];
                e_tag[k] = req_tag[win*5 +: 5];
                e_id[k]  = win;
                ptr[k]   = (win + 1) % N;
            end else if (responding && resp_ready) begin
                busy[k] = 1'b0;
                if (k == 0) begin
                    data_log.push_back(o_data[0]);
                    id_log.push_back(int'(o_id[0]));
                end
            end
            if (k == 0 && o_rdy[0] != 2'b00) grant_log.push_back(o_rdy[0]);
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        if (r[3:0] == 4'h0) return 32'h0;
        e = (r[3:0] == 4'h1) ? 8'(200 + r[9:4] % 50) : 8'(100 + r[9:4] % 55);
        return {r[31], e, r[30:20], 12'h0};
    endfunction

    task automatic drain(input int n);
        req_valid  = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        req_valid = 2'b00;
        rst_n     = 1'b1;
        @(posedge CLK);
        #1;

        // Both requesters continuously valid: grants alternate starting from req0.
        req_rs1   = {32'hC000_0000, 32'h3FC0_0000};
        req_rs2   = {32'h4040_0000, 32'h3FC0_0000};
        req_tag   = {5'd9, 5'd4};
        req_valid = 2'b11;
        repeat (14) step();
        chk("A_grant_count", 64'(grant_log.size() >= 3), 64'(1));
        chk("A_grant0", 64'(grant_log[0]), 64'(2'b01));
        chk("A_grant1", 64'(grant_log[1]), 64'(2'b10));
        chk("A_grant2", 64'(grant_log[2]), 64'(2'b01));
        chk("A_resp0", {31'h0, id_log[0] != 0, data_log[0]}, {32'h0, 32'h4010_0000});
        chk("A_resp1", {31'h0, id_log[1] != 0, data_log[1]}, {32'h1, 32'hC0C0_0000});
        drain(6);

        // Single request, two-cycle latency on the MUL_LAT=1 instance.
        req_rs1[31:0] = 32'h4000_0000;
        req_rs2[31:0] = 32'h4040_0000;
        req_tag[4:0]  = 5'd3;
        req_valid     = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        chk("B_valid", 64'(rv_a), 64'(1));
        chk("B_data", 64'(data_a), 64'(32'h40C0_0000));
        chk("B_id_tag_ovf", {57'h0, id_a, tag_a, ovf_a}, {57'h0, 1'b0, 5'd3, 1'b0});
        step();
        step();
        chk("B_data_lat3", 64'(data_b), 64'(32'h40C0_0000));
        drain(4);

        // Backpressure: response held and no grants until accepted.
        resp_ready    = 1'b0;
        req_rs1[63:32] = rnd_fp();
        req_rs2[63:32] = rnd_fp();
        req_valid     = 2'b10;
        step();
        req_valid = 2'b11;
        repeat (8) step();
        chk("C_ready_held", 64'(rdy_a), 64'(0));
        chk("C_valid_held", 64'(rv_a), 64'(1));
        resp_ready = 1'b1;
        repeat (4) step();
        drain(6);

        // Overflow and zero operands.
        req_rs1[31:0] = 32'h7F00_0000;
        req_rs2[31:0] = 32'h7F00_0000;
        req_valid     = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        chk("D_overflow", 64'(ovf_a), 64'(1));
        drain(4);
        req_rs1[31:0] = 32'h0000_0000;
        req_rs2[31:0] = 32'h40A0_0000;
        req_valid     = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        chk("D_zero", {31'h0, ovf_a, data_a}, 64'(0));
        drain(4);

        // Flush hits RESP on the MUL_LAT=1 instance and LAUNCH on the MUL_LAT=3 one.
        // The last grant above went to req0, so req1 wins next and req0 after the flush.
        resp_ready = 1'b0;
        req_rs1    = {rnd_fp(), rnd_fp()};
        req_rs2    = {rnd_fp(), rnd_fp()};
        req_valid  = 2'b11;
        #1;
        chk("E_first_grant", 64'(rdy_a), 64'(2'b10));
        step();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("E_flushed", {60'h0, rv_a, en_a, rv_b, en_b}, 64'(0));
        #1;
        chk("E_next_grant", 64'(rdy_a), 64'(2'b01));
        chk("E_next_grant_b", 64'(rdy_b), 64'(2'b01));
        step();
        drain(6);

        // Asynchronous reset in the middle of LAUNCH.
        req_rs1[31:0] = rnd_fp();
        req_rs2[31:0] = rnd_fp();
        req_valid     = 2'b10;
        step();
        req_valid = 2'b00;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        rst_n = 1'b1;
        reset_model();
        req_valid = 2'b11;
        #1;
        chk("F_first_grant", 64'(rdy_a), 64'(2'b01));
        chk("F_first_grant_b", 64'(rdy_b), 64'(2'b01));
        step();
        drain(6);

        // Randomized traffic, backpressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            req_valid  = 2'($urandom);
            req_rs1    = {rnd_fp(), rnd_fp()};
            req_rs2    = {rnd_fp(), rnd_fp()};
            req_tag    = 10'($urandom);
            resp_ready = ($urandom % 10) < 7;
            flush      = ($urandom % 32) == 0;
            step();
        end
        drain(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
